// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC controller: FSM state encodings,
// the PC step and the default reset PC (BIOS base).
package fetch_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned ST_W     = 2;
  localparam int unsigned PERF_W   = 32;
  // Squash counter holds SQUASH_CYCLES-1, SQUASH_CYCLES limited to 1..3
  localparam int unsigned SQ_CNT_W = 2;

  localparam logic [ST_W-1:0] BOOT   = 2'd0;
  localparam logic [ST_W-1:0] RUN    = 2'd1;
  localparam logic [ST_W-1:0] SQUASH = 2'd2;

  localparam logic [PC_W-1:0] PC_INC       = 32'd4;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h4000_0000;

endpackage

// File: rtl/br_perf_cnt.sv
// Branch performance counters (present only when BR_PERF_CNT_EN is defined).
// Counts live, non-stalled conditional branches and how many of them were taken.
// Ports:
//   clk, rst                 clock, async active-high reset
//   stall                    hazard hold; a stalled branch is not counted
//   ex_valid, ex_is_branch   execute-stage branch qualifier
//   ex_taken                 branch outcome
//   br_cnt, br_taken_cnt     free-running counters, wrap at 2^32
`ifdef BR_PERF_CNT_EN
module br_perf_cnt
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  output logic [PERF_W-1:0] br_cnt,
  output logic [PERF_W-1:0] br_taken_cnt
);

  logic br_seen;

  assign br_seen = ex_valid & ex_is_branch & ~stall;

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (br_seen) begin
      br_cnt <= br_cnt + PERF_W'(1);
      if (ex_taken) br_taken_cnt <= br_taken_cnt + PERF_W'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC controller. Owns the fetch PC, redirects on taken branches and
// jumps from execute, flushes IF/ID on a redirect and marks fetch output invalid
// while the synchronous memory returns data for a stale address.
// Optional macro BR_PERF_CNT_EN adds br_cnt / br_taken_cnt outputs.
// Ports:
//   clk, rst           clock, async active-high reset
//   stall              freezes pc and squash counter (a redirect still wins)
//   ex_valid           execute instruction is live
//   ex_is_branch       conditional branch
//   ex_taken           branch condition result
//   ex_is_jump         jal/jalr
//   ex_target          redirect target
//   pc                 fetch address
//   pc_valid           data fetched at the previous pc is usable
//   flush              combinational kill of IF/ID, equals take
//   misalign_err       sticky, set when a redirect target has bit 1 set
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC      = RESET_PC_DEF,
  parameter int unsigned     SQUASH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic              ex_is_jump,
  input  logic [PC_W-1:0]   ex_target,
  output logic [PC_W-1:0]   pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              misalign_err
`ifdef BR_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] br_cnt,
  output logic [PERF_W-1:0] br_taken_cnt
`endif
);

  localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_CYCLES - 1);

  logic [ST_W-1:0]     state;
  logic [ST_W-1:0]     state_next;
  logic [PC_W-1:0]     pc_next;
  logic [SQ_CNT_W-1:0] sq_cnt;
  logic [SQ_CNT_W-1:0] sq_cnt_next;
  logic                err_next;
  logic                take;

  assign take  = ex_valid & (ex_is_jump | (ex_is_branch & ex_taken));
  assign flush = take;

  // State register; pc_valid is registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      sq_cnt       <= '0;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      sq_cnt       <= sq_cnt_next;
      pc_valid     <= (state_next == RUN);
      misalign_err <= err_next;
    end
  end

  // Next-state: redirect beats stall beats increment, in every state
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    sq_cnt_next = sq_cnt;
    err_next    = misalign_err;
    if (take) begin
      pc_next     = {ex_target[PC_W-1:2], 2'b00};
      state_next  = SQUASH;
      sq_cnt_next = SQ_LOAD;
      if (ex_target[1]) err_next = 1'b1;
    end else if (!stall) begin
      pc_next = pc + PC_INC;
      case (state)
        BOOT:   state_next = RUN;
        SQUASH: begin
          if (sq_cnt == '0) state_next = RUN;
          else              sq_cnt_next = sq_cnt - SQ_CNT_W'(1);
        end
        RUN:     state_next = RUN;
        default: state_next = BOOT;
      endcase
    end
  end

`ifdef BR_PERF_CNT_EN
  br_perf_cnt u_br_perf_cnt (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_taken     (ex_taken),
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl. Stimulus pushes the reference model's
// expected outputs into a queue; a monitor pops and compares at each falling edge.
module tb_fetch_pc_ctrl;

  localparam int unsigned SQ  = 2;
  localparam logic [31:0] RPC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic        ex_is_jump;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        misalign_err;
`ifdef BR_PERF_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;
`endif

  fetch_pc_ctrl #(.RESET_PC(RPC), .SQUASH_CYCLES(SQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_taken     (ex_taken),
    .ex_is_jump   (ex_is_jump),
    .ex_target    (ex_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .misalign_err (misalign_err)
`ifdef BR_PERF_CNT_EN
    ,
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        err;
    logic [31:0] bc;
    logic [31:0] btc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: address, "still booting" flag, and the number of
  // non-stalled edges that must pass before fetch data becomes usable again.
  logic [31:0] m_pc;
  bit          m_boot;
  int          m_left;
  bit          m_err;
  logic [31:0] m_bc;
  logic [31:0] m_btc;

  function automatic void model_reset();
    m_pc   = RPC;
    m_boot = 1'b1;
    m_left = 0;
    m_err  = 1'b0;
    m_bc   = '0;
    m_btc  = '0;
  endfunction

  function automatic bit model_take();
    return ex_valid && (ex_is_jump || (ex_is_branch && ex_taken));
  endfunction

  function automatic void push_expected();
    exp_t x;
    x.pc       = m_pc;
    x.pc_valid = !m_boot && (m_left == 0);
    x.flush    = model_take();
    x.err      = m_err;
    x.bc       = m_bc;
    x.btc      = m_btc;
    q.push_back(x);
  endfunction

  function automatic void model_step();
    if (ex_valid && ex_is_branch && !stall) begin
      m_bc = m_bc + 1;
      if (ex_taken) m_btc = m_btc + 1;
    end
    if (model_take()) begin
      m_pc   = ex_target & 32'hFFFF_FFFC;
      m_left = SQ;
      m_boot = 1'b0;
      if (ex_target[1]) m_err = 1'b1;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
      if (m_boot)          m_boot = 1'b0;
      else if (m_left > 0) m_left = m_left - 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, record expectation, advance model at the edge
  task automatic drive(input bit s, input bit v, input bit br, input bit tk,
                       input bit j, input logic [31:0] t);
    stall        = s;
    ex_valid     = v;
    ex_is_branch = br;
    ex_taken     = tk;
    ex_is_jump   = j;
    ex_target    = t;
    push_expected();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic stalled(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: outputs are presented every cycle, compare mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", 32'(pc_valid), 32'(e.pc_valid));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("misalign_err", 32'(misalign_err), 32'(e.err));
`ifdef BR_PERF_CNT_EN
        chk("br_cnt", br_cnt, e.bc);
        chk("br_taken_cnt", br_taken_cnt, e.btc);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    bit          s, v, br, tk, j;
    rst = 1'b1;
    stall = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_taken = 1'b0; ex_is_jump = 1'b0; ex_target = '0;
    model_reset();
    @(posedge clk); #1;
    push_expected();
    @(posedge clk); #1;
    rst = 1'b0;

    // Boot and run up to 4000_0010
    idle(4);
    // Taken branch redirect
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0100);
    idle(4);
    // Not-taken branch, invalid jump, invalid taken branch
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0200);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0200);
    idle(1);
    // Redirect under stall, bit0 ignored then bit1 flags misalignment
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0301);
    stalled(2);
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0302);
    idle(4);
    // Back-to-back redirects, second lands in SQUASH, then stall inside SQUASH
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_1000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_2000);
    stalled(2);
    idle(4);
    // Async reset in the middle of a squash
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_3000);
    stall = 1'b1; ex_valid = 1'b0; ex_is_jump = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    push_expected();
    @(posedge clk); #1;
    rst = 1'b0;
    stalled(2);
    idle(3);
    // Take while still in BOOT
    rst = 1'b1; #1; model_reset(); @(posedge clk); #1; rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_4000);
    idle(4);
    // Wrap at the top of the address space
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle(4);
    // Branch counting: 2 taken, 1 not taken, 1 stalled (not counted)
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_5000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_6000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_7000);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_8000);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      v   = ($urandom_range(0, 9) < 7);
      br  = $urandom_range(0, 1) == 1;
      tk  = $urandom_range(0, 1) == 1;
      j   = ($urandom_range(0, 7) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 15) != 0) tgt[1] = 1'b0;
      if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      drive(s, v, br, tk, j, tgt);
    end
    idle(2);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
